// File: rtl/mem_access_timed_fifo_pkg.sv
// Shared defaults and entry layout helpers for the timed memory-access FIFO.
// Entry layout, MSB to LSB: {ram, addr, in_time, out_time}.
package mem_access_timed_fifo_pkg;

  localparam int SIZE_ADDR     = 32;
  localparam int NUM_CH_DEF    = 4;
  localparam int CH_LOG_DEF    = 2;
  localparam int DEPTH_DEF     = 32;
  localparam int DEPTH_LOG_DEF = 5;
  localparam int RAM_LOG_DEF   = 5;
  localparam int CNT_W_DEF     = 16;
  localparam int DLY_W_DEF     = 10;

  function automatic int entry_w(input int ram_log, input int addr_w, input int cnt_w);
    return ram_log + addr_w + 2 * cnt_w;
  endfunction

endpackage

// File: rtl/mem_access_ch_fifo.sv
// One channel of the timed FIFO: ring pointers, level, full/empty and an
// asynchronously read storage array (distributed-RAM style, head always visible).
module mem_access_ch_fifo
  import mem_access_timed_fifo_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int DEPTH_LOG = DEPTH_LOG_DEF,
  parameter int W         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [W-1:0]         wdata,
  output logic [W-1:0]         rdata,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH_LOG:0]   level
);

  localparam logic [DEPTH_LOG:0] FULL_LVL = (DEPTH_LOG+1)'(DEPTH);

  logic [W-1:0]       mem [DEPTH];
  logic [DEPTH_LOG:0] wr_ptr;
  logic [DEPTH_LOG:0] rd_ptr;
  logic               wr_en;
  logic               rd_en;

  // Pointers carry one extra wrap bit so all DEPTH slots are usable.
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[DEPTH_LOG-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rdata = mem[rd_ptr[DEPTH_LOG-1:0]];

endmodule

// File: rtl/mem_access_timed_fifo.sv
// Multi-channel timed memory-access FIFO: entries leave through a round-robin
// valid/ready pop port once count_i reaches their release time.
// Optional statistics are built when MEM_ACCESS_TIMED_FIFO_STATS_EN is defined.
//
// Handshake: a push fires on push_valid_i & push_ready_o, a pop fires on
// pop_valid_o & pop_ready_i; both ready/valid are forced low while stall_i=1.
module mem_access_timed_fifo
  import mem_access_timed_fifo_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int CH_LOG    = CH_LOG_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int DEPTH_LOG = DEPTH_LOG_DEF,
  parameter int ADDR_W    = SIZE_ADDR,
  parameter int RAM_LOG   = RAM_LOG_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DLY_W     = DLY_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_i,
  input  logic [CNT_W-1:0]     count_i,
  input  logic                 push_valid_i,
  input  logic [CH_LOG-1:0]    push_ch_i,
  input  logic [RAM_LOG-1:0]   push_ram_i,
  input  logic [ADDR_W-1:0]    push_addr_i,
  input  logic [DLY_W-1:0]     delay_i,
  output logic                 push_ready_o,
  output logic                 pop_valid_o,
  input  logic                 pop_ready_i,
  output logic [CH_LOG-1:0]    pop_ch_o,
  output logic [RAM_LOG-1:0]   pop_ram_o,
  output logic [ADDR_W-1:0]    pop_addr_o,
  output logic [CNT_W-1:0]     pop_in_time_o,
  output logic [CNT_W-1:0]     pop_out_time_o,
  output logic [NUM_CH-1:0]    full_o,
  output logic [NUM_CH-1:0]    empty_o,
  output logic [CNT_W-1:0]     stat_late_o,
  output logic [DEPTH_LOG:0]   stat_maxlvl_o
);

  localparam int ENTRY_W  = entry_w(RAM_LOG, ADDR_W, CNT_W);
  localparam int OUT_LSB  = 0;
  localparam int IN_LSB   = CNT_W;
  localparam int ADDR_LSB = 2 * CNT_W;
  localparam int RAM_LSB  = 2 * CNT_W + ADDR_W;

  logic [ENTRY_W-1:0]      push_entry;
  logic [ENTRY_W-1:0]      head [NUM_CH];
  logic [ENTRY_W-1:0]      sel_entry;
  logic [DEPTH_LOG:0]      level [NUM_CH];
  logic [NUM_CH-1:0]       cand;
  logic [(1<<CH_LOG)-1:0]  full_pad;
  logic [CNT_W-1:0]        push_out_time;
  logic [CH_LOG-1:0]       rr_ptr;
  logic [CH_LOG-1:0]       sel;
  logic                    sel_valid;
  logic                    push_fire;
  logic                    pop_fire;

  assign push_out_time = count_i + CNT_W'(delay_i);
  assign push_entry    = {push_ram_i, push_addr_i, count_i, push_out_time};

  // Channel codes beyond NUM_CH read as full so they are never accepted.
  always_comb begin
    full_pad             = '1;
    full_pad[NUM_CH-1:0] = full_o;
  end

  assign push_ready_o = ~stall_i & ~full_pad[push_ch_i];
  assign push_fire    = push_valid_i & push_ready_o;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] slack;

    mem_access_ch_fifo #(
      .DEPTH     (DEPTH),
      .DEPTH_LOG (DEPTH_LOG),
      .W         (ENTRY_W)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .push  (push_fire & (push_ch_i == CH_LOG'(c))),
      .pop   (pop_fire & (sel == CH_LOG'(c))),
      .wdata (push_entry),
      .rdata (head[c]),
      .full  (full_o[c]),
      .empty (empty_o[c]),
      .level (level[c])
    );

    // Wrap-safe count_i >= out_time: the modular difference is non-negative.
    assign slack   = count_i - head[c][OUT_LSB +: CNT_W];
    assign cand[c] = ~empty_o[c] & ~slack[CNT_W-1];
  end

  // Round robin: lowest candidate at or above rr_ptr, else lowest overall.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (cand[c] && (CH_LOG'(c) >= rr_ptr)) begin
        sel       = CH_LOG'(c);
        sel_valid = 1'b1;
      end
    end
    if (!sel_valid) begin
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (cand[c]) begin
          sel       = CH_LOG'(c);
          sel_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_entry = head[0];
    for (int c = 1; c < NUM_CH; c++) begin
      if (sel == CH_LOG'(c)) sel_entry = head[c];
    end
  end

  assign pop_valid_o    = sel_valid & ~stall_i;
  assign pop_fire       = pop_valid_o & pop_ready_i;
  assign pop_ch_o       = sel;
  assign pop_ram_o      = sel_entry[RAM_LSB  +: RAM_LOG];
  assign pop_addr_o     = sel_entry[ADDR_LSB +: ADDR_W];
  assign pop_in_time_o  = sel_entry[IN_LSB   +: CNT_W];
  assign pop_out_time_o = sel_entry[OUT_LSB  +: CNT_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (pop_fire) begin
      rr_ptr <= (sel == CH_LOG'(NUM_CH - 1)) ? '0 : sel + CH_LOG'(1);
    end
  end

`ifdef MEM_ACCESS_TIMED_FIFO_STATS_EN
  logic [CNT_W-1:0]   late_q;
  logic [DEPTH_LOG:0] maxlvl_q;
  logic [DEPTH_LOG:0] lvl_peak;

  always_comb begin
    lvl_peak = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (level[c] > lvl_peak) lvl_peak = level[c];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      late_q   <= '0;
      maxlvl_q <= '0;
    end else if (!stall_i) begin
      if (pop_fire && (count_i != pop_out_time_o) && (late_q != '1))
        late_q <= late_q + 1'b1;
      if (lvl_peak > maxlvl_q) maxlvl_q <= lvl_peak;
    end
  end

  assign stat_late_o   = late_q;
  assign stat_maxlvl_o = maxlvl_q;
`else
  logic unused_lvl;

  always_comb begin
    unused_lvl = 1'b0;
    for (int c = 0; c < NUM_CH; c++) unused_lvl = unused_lvl ^ (^level[c]);
  end

  assign stat_late_o   = '0;
  assign stat_maxlvl_o = '0;
`endif

endmodule
